// File: rtl/id_branch_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// id_branch_hazard_ctrl
//
// Hazard control for a 5-stage RV32 pipeline that resolves conditional
// branches and JALR in the ID stage. Because the branch comparator in ID
// consumes forwarded operands, a control instruction must wait until its
// source registers can be forwarded:
//   - a load in EX producing a needed register costs two stall cycles,
//   - an ALU result in EX, or a load result in MEM, costs one stall cycle.
// A taken branch/JALR squashes the instruction fetched behind it, but only
// in a cycle where ID is not itself stalled.
//
// Ports
//   clk              in   clock, rising edge
//   rst              in   asynchronous active-high reset
//   ID_valid         in   ID holds a real instruction
//   ID_Opcode [6:0]  in   opcode in ID
//   ID_rs1/rs2 [4:0] in   source registers in ID
//   ID_branch_taken  in   branch/JALR resolved taken in ID
//   EX_RegWrite      in   EX instruction writes rd
//   EX_MemRead       in   EX instruction is a load
//   EX_rd [4:0]      in   EX destination register
//   MEM_RegWrite     in   MEM instruction writes rd
//   MEM_WBSrc        in   MEM result comes from memory (load)
//   MEM_rd [4:0]     in   MEM destination register
//   PC_Write         out  PC update enable
//   IFID_Write       out  IF/ID register update enable
//   IDEX_Bubble      out  inject a NOP into ID/EX
//   IFID_Flush       out  squash the fetched instruction
//   stall_cnt [15:0] out  saturating count of stall cycles
//   flush_cnt [15:0] out  saturating count of flush cycles
// ---------------------------------------------------------------------------
module id_branch_hazard_ctrl #(
  parameter logic [6:0] RV32_BRANCH = 7'b1100011,
  parameter logic [6:0] RV32_JALR   = 7'b1100111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ID_valid,
  input  logic [6:0]  ID_Opcode,
  input  logic [4:0]  ID_rs1,
  input  logic [4:0]  ID_rs2,
  input  logic        ID_branch_taken,
  input  logic        EX_RegWrite,
  input  logic        EX_MemRead,
  input  logic [4:0]  EX_rd,
  input  logic        MEM_RegWrite,
  input  logic        MEM_WBSrc,
  input  logic [4:0]  MEM_rd,
  output logic        PC_Write,
  output logic        IFID_Write,
  output logic        IDEX_Bubble,
  output logic        IFID_Flush,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  state_t state;
  state_t state_nxt;

  logic is_branch;
  logic is_jalr;
  logic ctrl;
  logic use_rs1;
  logic use_rs2;
  logic ex_match;
  logic mem_match;
  logic hz2;
  logic hz1;
  logic stall;
  logic flush;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] cnt,
                                          input logic        en);
    logic [15:0] res;
    res = cnt;
    if (en && (cnt != CNT_MAX)) begin
      res = cnt + 16'd1;
    end
    return res;
  endfunction

  // True when a producer's destination feeds a source that ID actually
  // reads. x0 is hard-wired to zero, so it can never carry a dependency.
  function automatic logic reg_match(input logic [4:0] rd,
                                     input logic [4:0] rs1,
                                     input logic [4:0] rs2,
                                     input logic       use1,
                                     input logic       use2);
    logic hit;
    hit = (use1 && (rs1 == rd)) || (use2 && (rs2 == rd));
    return (rd != 5'd0) && hit;
  endfunction

  // Decode: JALR only reads rs1; conditional branches compare rs1 and rs2.
  always_comb begin
    is_branch = (ID_Opcode == RV32_BRANCH);
    is_jalr   = (ID_Opcode == RV32_JALR);
    ctrl      = ID_valid && (is_branch || is_jalr);
    use_rs1   = ctrl;
    use_rs2   = ctrl && is_branch;
  end

  // Hazard detection against the EX and MEM producers.
  always_comb begin
    ex_match  = reg_match(EX_rd,  ID_rs1, ID_rs2, use_rs1, use_rs2);
    mem_match = reg_match(MEM_rd, ID_rs1, ID_rs2, use_rs1, use_rs2);

    // Load in EX: data is two cycles from being forwardable into ID.
    hz2 = EX_RegWrite && EX_MemRead && ex_match;

    // ALU result in EX, or load data still in MEM: one cycle away.
    hz1 = (EX_RegWrite && !EX_MemRead && ex_match) ||
          (MEM_RegWrite && MEM_WBSrc && mem_match);
  end

  // Stall FSM, next-state and stall output. HOLD supplies the second stall
  // cycle of a load-use; returning to IDLE re-evaluates hazards so a load
  // that has moved on to MEM is still caught by hz1 if it matches.
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    unique case (state)
      IDLE: begin
        stall = hz2 || hz1;
        // hz2 takes priority when both hazards are present.
        state_nxt = hz2 ? HOLD : IDLE;
      end
      HOLD: begin
        stall     = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        stall     = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // A stalled branch is re-evaluated next cycle, so it must not flush yet.
  always_comb begin
    flush = ctrl && ID_branch_taken && !stall;
  end

  assign PC_Write    = !stall;
  assign IFID_Write  = !stall;
  assign IDEX_Bubble = stall;
  assign IFID_Flush  = flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
    end else begin
      state     <= state_nxt;
      stall_cnt <= sat_inc(stall_cnt, stall);
      flush_cnt <= sat_inc(flush_cnt, flush);
    end
  end

endmodule

// File: tb/tb_id_branch_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_id_branch_hazard_ctrl
//
// Scoreboard bench: each cycle the expected outputs are computed from an
// independent behavioural model of the stall/flush rules, pushed to a queue
// when the inputs are driven, and popped and compared when the DUT outputs
// are sampled just before the next rising edge.
// ---------------------------------------------------------------------------
module tb_id_branch_hazard_ctrl;

  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_ALU  = 7'b0110011;

  logic        clk;
  logic        rst;
  logic        ID_valid;
  logic [6:0]  ID_Opcode;
  logic [4:0]  ID_rs1;
  logic [4:0]  ID_rs2;
  logic        ID_branch_taken;
  logic        EX_RegWrite;
  logic        EX_MemRead;
  logic [4:0]  EX_rd;
  logic        MEM_RegWrite;
  logic        MEM_WBSrc;
  logic [4:0]  MEM_rd;
  logic        PC_Write;
  logic        IFID_Write;
  logic        IDEX_Bubble;
  logic        IFID_Flush;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  id_branch_hazard_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .ID_valid        (ID_valid),
    .ID_Opcode       (ID_Opcode),
    .ID_rs1          (ID_rs1),
    .ID_rs2          (ID_rs2),
    .ID_branch_taken (ID_branch_taken),
    .EX_RegWrite     (EX_RegWrite),
    .EX_MemRead      (EX_MemRead),
    .EX_rd           (EX_rd),
    .MEM_RegWrite    (MEM_RegWrite),
    .MEM_WBSrc       (MEM_WBSrc),
    .MEM_rd          (MEM_rd),
    .PC_Write        (PC_Write),
    .IFID_Write      (IFID_Write),
    .IDEX_Bubble     (IDEX_Bubble),
    .IFID_Flush      (IFID_Flush),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        pcw;
    logic        ifw;
    logic        bub;
    logic        fl;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  exp_t  sbq[$];
  int    checks;
  int    errors;
  string scen;

  // Model state
  bit          m_hold;
  logic [15:0] m_sc;
  logic [15:0] m_fc;
  bit          m_h2;
  bit          m_stall;
  bit          m_flush;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s/%s got=%h exp=%h", scen, tag, got, exp);
    end
  endtask

  task automatic drive(input bit v, input logic [6:0] opc,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input bit tk, input bit exw, input bit exm,
                       input logic [4:0] exrd, input bit mw, input bit mwb,
                       input logic [4:0] mrd);
    ID_valid        = v;
    ID_Opcode       = opc;
    ID_rs1          = rs1;
    ID_rs2          = rs2;
    ID_branch_taken = tk;
    EX_RegWrite     = exw;
    EX_MemRead      = exm;
    EX_rd           = exrd;
    MEM_RegWrite    = mw;
    MEM_WBSrc       = mwb;
    MEM_rd          = mrd;
  endtask

  task automatic idle_in();
    drive(0, 7'd0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 5'd0);
  endtask

  // Behavioural model of the expected outputs for the current inputs.
  function automatic exp_t model_out();
    exp_t e;
    bit   is_ctrl, rd1, rd2, dep_ex, dep_mem, h1;
    is_ctrl = ID_valid && (ID_Opcode == OP_BR || ID_Opcode == OP_JALR);
    rd1     = is_ctrl;
    rd2     = is_ctrl && (ID_Opcode == OP_BR);
    dep_ex  = (EX_rd != 0) &&
              ((rd1 && ID_rs1 == EX_rd) || (rd2 && ID_rs2 == EX_rd));
    dep_mem = (MEM_rd != 0) &&
              ((rd1 && ID_rs1 == MEM_rd) || (rd2 && ID_rs2 == MEM_rd));
    m_h2    = EX_RegWrite && EX_MemRead && dep_ex;
    h1      = (EX_RegWrite && !EX_MemRead && dep_ex) ||
              (MEM_RegWrite && MEM_WBSrc && dep_mem);
    m_stall = m_hold || m_h2 || h1;
    m_flush = is_ctrl && ID_branch_taken && !m_stall;
    e.pcw = !m_stall;
    e.ifw = !m_stall;
    e.bub = m_stall;
    e.fl  = m_flush;
    e.sc  = m_sc;
    e.fc  = m_fc;
    return e;
  endfunction

  // One clock: called at a falling edge with inputs already driven.
  task automatic cycle(input bit do_chk);
    exp_t e;
    exp_t g;
    if (rst) begin
      m_hold = 0;
      m_sc   = 16'd0;
      m_fc   = 16'd0;
    end
    e = model_out();
    sbq.push_back(e);
    #2;
    g = sbq.pop_front();
    if (do_chk) begin
      chk("PC_Write",    16'(PC_Write),    16'(g.pcw));
      chk("IFID_Write",  16'(IFID_Write),  16'(g.ifw));
      chk("IDEX_Bubble", 16'(IDEX_Bubble), 16'(g.bub));
      chk("IFID_Flush",  16'(IFID_Flush),  16'(g.fl));
      chk("stall_cnt",   stall_cnt,        g.sc);
      chk("flush_cnt",   flush_cnt,        g.fc);
    end
    @(posedge clk);
    if (!rst) begin
      m_hold = !m_hold && m_h2;
      if (m_stall && m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
      if (m_flush && m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1'b1;
    cycle(1);
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_hold = 0;
    m_sc   = 16'd0;
    m_fc   = 16'd0;
    rst    = 1'b1;
    idle_in();
    scen = "reset";
    @(negedge clk);
    cycle(1);
    // Hazard present during reset: outputs still follow IDLE equations.
    drive(1, OP_BR, 5'd3, 5'd4, 0, 1, 0, 5'd3, 0, 0, 5'd0);
    cycle(1);
    chk("rst_stall_cnt", stall_cnt, 16'd0);
    idle_in();
    rst = 1'b0;

    // BEQ x5,x6 behind ADD x5: one stall cycle.
    scen = "alu_ex";
    do_reset();
    drive(1, OP_BR, 5'd5, 5'd6, 0, 1, 0, 5'd5, 0, 0, 5'd0);
    cycle(1);
    drive(1, OP_BR, 5'd5, 5'd6, 0, 0, 0, 5'd0, 1, 0, 5'd5);
    cycle(1);
    chk("cnt_fixed", stall_cnt, 16'd1);

    // BNE x7,x0 behind LW x7: two stall cycles then release.
    scen = "load_ex";
    do_reset();
    drive(1, OP_BR, 5'd7, 5'd0, 1, 1, 1, 5'd7, 0, 0, 5'd0);
    cycle(1);
    drive(1, OP_BR, 5'd7, 5'd0, 1, 0, 0, 5'd0, 1, 1, 5'd7);
    cycle(1);
    drive(1, OP_BR, 5'd7, 5'd0, 1, 0, 0, 5'd0, 0, 0, 5'd0);
    cycle(1);
    chk("stall_fixed", stall_cnt, 16'd2);
    chk("flush_fixed", flush_cnt, 16'd1);

    // JALR x1 with ADD x9 in EX: rs2 ignored, taken flushes.
    scen = "jalr_rs2";
    do_reset();
    drive(1, OP_JALR, 5'd1, 5'd9, 1, 1, 0, 5'd9, 0, 0, 5'd0);
    cycle(1);
    idle_in();
    cycle(1);
    chk("flush_fixed", flush_cnt, 16'd1);
    chk("stall_fixed", stall_cnt, 16'd0);

    // BEQ x0,x0 behind LW x0: no hazard, taken flushes.
    scen = "x0";
    do_reset();
    drive(1, OP_BR, 5'd0, 5'd0, 1, 1, 1, 5'd0, 1, 1, 5'd0);
    cycle(1);

    // Assorted patterns, including ones that must not stall or flush.
    scen = "mix";
    do_reset();
    // JALR rs1 matches a load in MEM: one stall.
    drive(1, OP_JALR, 5'd12, 5'd0, 1, 0, 0, 5'd0, 1, 1, 5'd12);
    cycle(1);
    // ALU result in MEM is already forwardable: no stall.
    drive(1, OP_BR, 5'd12, 5'd13, 1, 0, 0, 5'd0, 1, 0, 5'd13);
    cycle(1);
    // Non-control instruction never stalls or flushes.
    drive(1, OP_ALU, 5'd8, 5'd8, 1, 1, 1, 5'd8, 1, 1, 5'd8);
    cycle(1);
    // Invalid ID slot never stalls or flushes.
    drive(0, OP_BR, 5'd8, 5'd8, 1, 1, 1, 5'd8, 0, 0, 5'd0);
    cycle(1);
    // hz2 and hz1 together: HOLD path, two stalls, then flush.
    drive(1, OP_BR, 5'd5, 5'd6, 1, 1, 1, 5'd5, 1, 1, 5'd6);
    cycle(1);
    drive(1, OP_BR, 5'd5, 5'd6, 1, 0, 0, 5'd0, 1, 1, 5'd5);
    cycle(1);
    drive(1, OP_BR, 5'd5, 5'd6, 1, 0, 0, 5'd0, 0, 0, 5'd0);
    cycle(1);
    // Random patterns over a small register set.
    for (int i = 0; i < 40; i++) begin
      drive($urandom_range(0, 1) == 1,
            ($urandom_range(0, 2) == 0) ? OP_ALU :
              (($urandom_range(0, 1) == 1) ? OP_BR : OP_JALR),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            5'($urandom_range(0, 3)));
      cycle(1);
    end

    // Asynchronous reset in HOLD: immediate IDLE, no residual stall.
    scen = "async_rst";
    do_reset();
    drive(1, OP_BR, 5'd7, 5'd0, 0, 1, 1, 5'd7, 0, 0, 5'd0);
    cycle(1);
    idle_in();
    drive(1, OP_BR, 5'd7, 5'd0, 0, 0, 0, 5'd0, 0, 0, 5'd0);
    rst = 1'b1;
    #1;
    chk("bubble_now", 16'(IDEX_Bubble), 16'd0);
    chk("stall_cnt_now", stall_cnt, 16'd0);
    cycle(1);
    rst = 1'b0;
    cycle(1);
    cycle(1);

    // Saturation of stall_cnt.
    scen = "sat";
    do_reset();
    drive(1, OP_BR, 5'd5, 5'd6, 0, 1, 0, 5'd5, 0, 0, 5'd0);
    for (int i = 0; i < 65534; i++) cycle(0);
    chk("preload", stall_cnt, 16'hFFFE);
    cycle(1);
    cycle(1);
    cycle(1);
    chk("held", stall_cnt, 16'hFFFF);

    chk("sbq_empty", 16'(sbq.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
